// File: rtl/spart_tx_arbiter.sv
// spart_tx_arbiter
// Round-robin transmit scheduler for the SPART serial port. Several byte
// producers share one TXD line; one byte is accepted at a time over a
// valid/ready handshake and sent as an 8N1 frame. Bit timing is taken from
// the write baud generator strobe (baud_tick).

module spart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 txd,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        STOP
    } stateT;

    stateT               state;
    stateT               stateNext;

    // Byte being transmitted, captured only in the acceptance cycle
    logic [7:0]          txByte;
    logic [7:0]          txByteNext;

    // Index of the data bit currently on the line while in DATA
    logic [2:0]          bitCnt;
    logic [2:0]          bitCntNext;

    // Round-robin pointer: most recently granted client
    logic [ID_W-1:0]     lastIdx;
    logic [ID_W-1:0]     lastIdxNext;

    // Next values of the registered outputs
    logic                txdNext;
    logic                busyNext;
    logic                frameDoneNext;
    logic [NUM_REQ-1:0]  readyNext;
    logic [ID_W-1:0]     grantIdNext;

    // Per-client byte view of the flat data bus
    logic [7:0]          reqByte [NUM_REQ];

    // Arbiter result
    logic                grantFound;
    logic [ID_W-1:0]     grantIdx;
    logic [7:0]          grantByte;
    logic [NUM_REQ-1:0]  grantOneHot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_byte
            assign reqByte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Round-robin search: first valid client starting at lastIdx+1 (mod NUM_REQ).
    // Offsets are scanned from farthest to nearest so the nearest hit wins.
    always_comb begin
        grantFound  = 1'b0;
        grantIdx    = '0;
        grantByte   = '0;
        grantOneHot = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && (i == ((int'(lastIdx) + k) % NUM_REQ))) begin
                    grantFound  = 1'b1;
                    grantIdx    = ID_W'(i);
                    grantByte   = reqByte[i];
                    grantOneHot = NUM_REQ'(1) << i;
                end
            end
        end
    end

    // Frame sequencer: next state and next values of every registered output
    always_comb begin
        stateNext     = state;
        txByteNext    = txByte;
        bitCntNext    = bitCnt;
        lastIdxNext   = lastIdx;
        txdNext       = txd;
        busyNext      = busy;
        readyNext     = '0;
        grantIdNext   = grant_id;
        frameDoneNext = 1'b0;

        case (state)
            IDLE: begin
                // baud_tick plays no part here; only a pending request moves us on
                if (grantFound) begin
                    readyNext   = grantOneHot;
                    txByteNext  = grantByte;
                    grantIdNext = grantIdx;
                    lastIdxNext = grantIdx;
                    busyNext    = 1'b1;
                    stateNext   = WAIT;
                end
            end

            WAIT: begin
                // req_ready is high exactly in the acceptance cycle; a tick that
                // coincides with it must not start the frame
                if (baud_tick && (req_ready == '0)) begin
                    txdNext   = 1'b0;
                    stateNext = START;
                end
            end

            START: begin
                if (baud_tick) begin
                    txdNext    = txByte[0];
                    bitCntNext = 3'd0;
                    stateNext  = DATA;
                end
            end

            DATA: begin
                if (baud_tick) begin
                    if (bitCnt == 3'd7) begin
                        txdNext   = 1'b1;
                        stateNext = STOP;
                    end else begin
                        bitCntNext = bitCnt + 3'd1;
                        txdNext    = txByte[bitCnt + 3'd1];
                    end
                end
            end

            STOP: begin
                if (baud_tick) begin
                    busyNext      = 1'b0;
                    frameDoneNext = 1'b1;
                    stateNext     = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and output registers; reset puts the line idle and client 0 first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            txByte     <= '0;
            bitCnt     <= '0;
            lastIdx    <= ID_W'(NUM_REQ - 1);
            txd        <= 1'b1;
            busy       <= 1'b0;
            req_ready  <= '0;
            grant_id   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= stateNext;
            txByte     <= txByteNext;
            bitCnt     <= bitCntNext;
            lastIdx    <= lastIdxNext;
            txd        <= txdNext;
            busy       <= busyNext;
            req_ready  <= readyNext;
            grant_id   <= grantIdNext;
            frame_done <= frameDoneNext;
        end
    end

endmodule

// File: tb/tb_spart_tx_arbiter.sv
// Directed testbench for spart_tx_arbiter (NUM_REQ=4). Inputs are driven on
// the falling clock edge and outputs are sampled on the falling edge.

module tb_spart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk;
    logic                 rst;
    logic                 baud_tick;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 txd;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;
    logic                 frame_done;

    int testCount;
    int failCount;

    spart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .txd       (txd),
        .busy      (busy),
        .grant_id  (grant_id),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyReset();
        rst       = 1'b1;
        baud_tick = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One-cycle baud strobe; returns on the falling edge after it was sampled
    task automatic pulseTick();
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    // Present requests, check the grant in the acceptance cycle, then check
    // the ready pulse ended and the line is still idle one cycle later.
    task automatic acceptCheck(input logic [NUM_REQ-1:0] valid, input int expId, input bit tickInAccept);
        req_valid = valid;
        @(negedge clk);
        checkVal("req_ready", 32'(req_ready), 32'(1) << expId);
        checkVal("grant_id", 32'(grant_id), 32'(expId));
        checkVal("busy_accept", 32'(busy), 32'd1);
        if (tickInAccept)
            baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
        checkVal("ready_one_cycle", 32'(req_ready), 32'd0);
        checkVal("txd_wait", 32'(txd), 32'd1);
        $display("[TB] grant client %0d (valid=%b, tick in accept=%0d)", expId, valid, tickInAccept);
    endtask

    // Drive T0..T10 and check the line; optionally overwrite a client's data
    // just before tick number mutateAt.
    task automatic runFrame(input logic [7:0] expByte, input int mutateAt,
                            input logic [7:0] mutateData, input int mutateClient);
        logic [9:0] bits;
        bits = {1'b1, expByte, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == mutateAt)
                req_data[8*mutateClient +: 8] = mutateData;
            pulseTick();
            checkVal($sformatf("txd_T%0d", i), 32'(txd), 32'(bits[i]));
            if (i == 5) begin
                checkVal("busy_mid", 32'(busy), 32'd1);
                checkVal("ready_mid", 32'(req_ready), 32'd0);
            end
            @(negedge clk);
        end
        pulseTick();
        checkVal("frame_done_T10", 32'(frame_done), 32'd1);
        checkVal("busy_T10", 32'(busy), 32'd0);
        $display("[TB] frame byte %02h done", expByte);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst       = 1'b1;
        baud_tick = 1'b0;
        req_valid = '0;
        req_data  = '0;
        applyReset();

        // Reset state
        checkVal("rst_txd", 32'(txd), 32'd1);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_ready", 32'(req_ready), 32'd0);
        checkVal("rst_grant_id", 32'(grant_id), 32'd0);
        checkVal("rst_frame_done", 32'(frame_done), 32'd0);

        // Tick with nothing pending does nothing
        pulseTick();
        checkVal("idle_tick_txd", 32'(txd), 32'd1);
        checkVal("idle_tick_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Single frame: client 2 sends 0xA5
        req_data = 32'h00A5_0000;
        acceptCheck(4'b0100, 2, 1'b0);
        req_valid = '0;
        runFrame(8'hA5, -1, 8'h00, 0);
        @(negedge clk);
        checkVal("frame_done_clear", 32'(frame_done), 32'd0);
        checkVal("grant_id_hold", 32'(grant_id), 32'd2);

        // Round robin with all clients held valid
        applyReset();
        req_data = 32'h1312_1110;
        for (int n = 0; n < 5; n++) begin
            acceptCheck(4'b1111, n % 4, 1'b0);
            runFrame(8'h10 + 8'(n % 4), -1, 8'h00, 0);
        end
        req_valid = '0;
        @(negedge clk);

        // Fairness after skip: last=1, clients 0 and 3 valid -> 3 then 0
        applyReset();
        req_data = 32'hF000_810F;
        acceptCheck(4'b0010, 1, 1'b0);
        req_valid = '0;
        runFrame(8'h81, -1, 8'h00, 0);
        acceptCheck(4'b1001, 3, 1'b0);
        req_valid = 4'b0001;
        runFrame(8'hF0, -1, 8'h00, 0);
        acceptCheck(4'b0001, 0, 1'b0);
        req_valid = '0;
        runFrame(8'h0F, -1, 8'h00, 0);
        @(negedge clk);

        // Tick collision in the acceptance cycle
        applyReset();
        req_data = 32'h0000_3C00;
        acceptCheck(4'b0010, 1, 1'b1);
        req_valid = '0;
        runFrame(8'h3C, -1, 8'h00, 0);
        @(negedge clk);

        // Mid-frame reset at T4 of a 0xFF frame from client 0
        applyReset();
        req_data = 32'h0000_77FF;
        acceptCheck(4'b0001, 0, 1'b0);
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            pulseTick();
            checkVal($sformatf("ff_txd_T%0d", i), 32'(txd), (i == 0) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        checkVal("ff_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkVal("async_rst_txd", 32'(txd), 32'd1);
        checkVal("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        acceptCheck(4'b0011, 0, 1'b0);
        req_valid = '0;
        runFrame(8'hFF, -1, 8'h00, 0);
        @(negedge clk);

        // Data stability: client 3 changes its byte during DATA
        applyReset();
        req_data = 32'h5A00_0000;
        acceptCheck(4'b1000, 3, 1'b0);
        req_valid = '0;
        runFrame(8'h5A, 3, 8'h00, 3);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/spart_tx_arbiter.md
# spart_tx_arbiter

Round-robin transmit scheduler for the SPART serial port. It shares the single TXD line between `NUM_REQ` byte-producing clients. It accepts one byte at a time over a valid/ready handshake and serializes it as an 8N1 frame. Bit timing comes from the `txEnable` pulse of the write baud generator, so this block is the sequencer between the baud generator and the pin.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default 2: width of `grant_id`; must satisfy 2^ID_W >= NUM_REQ.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `baud_tick` input 1: one-cycle bit-rate strobe, connected to baud generator `txEnable`.
- `req_valid` input NUM_REQ: bit i high means client i holds a byte on its data slice.
- `req_data` input 8*NUM_REQ: client i byte is bits [8i+7:8i].
- `req_ready` output NUM_REQ: one-hot, one-cycle accept pulse to the granted client.
- `txd` output 1: serial line, idle high.
- `busy` output 1: high from the acceptance cycle until the frame ends.
- `grant_id` output ID_W: index of the client whose frame is in flight; holds its value after the frame.
- `frame_done` output 1: one-cycle pulse when the stop bit completes.

## Operation
- Reset values:
  - `txd`=1, `busy`=0, `req_ready`=0, `grant_id`=0, `frame_done`=0.
  - State = IDLE, bit counter = 0.
  - Round-robin pointer `last` = NUM_REQ-1, so client 0 has first priority.
- States: IDLE, WAIT, START, DATA, STOP. All outputs are registered.
- IDLE:
  - If any `req_valid` bit is high, grant the first valid index searching `last+1, last+2, …` modulo NUM_REQ.
  - On grant: pulse that client's `req_ready` for one cycle, latch its byte into the shift register, set `grant_id` and `last` to that index, set `busy`=1, go to WAIT.
  - If no `req_valid` bit is high, stay in IDLE.
  - `baud_tick` is ignored in IDLE.
- WAIT: `txd` stays 1. On `baud_tick`, set `txd`=0 and go to START.
- START: on `baud_tick`, set `txd`=data[0], bit counter = 0, go to DATA.
- DATA:
  - On `baud_tick` with counter < 7: counter increments and `txd`=data[counter+1] (LSB first).
  - On `baud_tick` with counter = 7: set `txd`=1 and go to STOP.
- STOP: on `baud_tick`, set `busy`=0 and pulse `frame_done`; go to IDLE.
- Requester protocol:
  - A client holds `req_valid` and its data stable until it sees `req_ready`.
  - Dropping `req_valid` before it is granted is legal; that client is then simply not granted.
  - Data is sampled only in the acceptance cycle. Later changes to `req_data` do not affect the frame in flight.
- `req_valid` is ignored outside IDLE. At most one `req_ready` bit is ever high.

## Timing
- Acceptance: the cycle after `req_valid` is seen in IDLE, `req_ready` and `busy` are high.
- A `baud_tick` that arrives in the same cycle as acceptance is not counted; WAIT needs a later tick.
- Ticks are counted from the first tick taken in WAIT, as T0:
  - T0: `txd` falls (start bit).
  - T1..T8: data bits 0..7.
  - T9: `txd` rises (stop bit).
  - T10: `busy` falls and `frame_done` pulses.
  - Every `txd` change is registered on the cycle after the tick is sampled.
- Minimum frame-to-frame gap: acceptance occurs in the cycle after T10. Transmission then waits for the next tick, so back-to-back frames have one extra idle-high bit period between them.
- Reset asserted mid-frame:
  - `txd` returns to 1 and `busy` to 0 immediately; the partial byte is discarded.
  - The round-robin pointer returns to NUM_REQ-1.
- `baud_tick` held high for several consecutive cycles is out of spec. The block advances one bit per high cycle without guarding against it.

## Test plan
- Single frame: after reset, client 2 presents 0xA5 with NUM_REQ=4. Required: `req_ready`=4'b0100 for one cycle and `grant_id`=2. TXD across T0..T9 is 0,1,0,1,0,0,1,0,1,1. `frame_done` pulses at T10.
- Round robin: all four `req_valid` bits held high with bytes 0x10..0x13. Grants arrive in order 0,1,2,3,0, with each client's byte appearing on `txd` in that order.
- Fairness after skip: `last`=1 with only clients 0 and 3 valid. Required: client 3 is granted next, then client 0.
- Tick collision: `baud_tick` pulses in the acceptance cycle. Required: `txd` stays 1 until the following tick; the frame still carries exactly 10 bits.
- Mid-frame reset: assert `rst` at T4 of a 0xFF frame. Required: `txd`=1 and `busy`=0 asynchronously. After release, the next request from client 0 is granted first.
- Data stability: change `req_data` during DATA. Required: the transmitted byte equals the value latched at acceptance.
